// File: rtl/debounce_sync.sv
// debounce_sync: two-flop synchronizer followed by a four-state debounce FSM.
// A new input level is accepted only after it has been seen on the
// synchronized input for DEBOUNCE_CYCLES consecutive clocks. The debounced
// level and the one-cycle edge strobes all come straight from flip-flops.
module debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic d_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam logic [1:0] STABLE_LOW  = 2'd0;
  localparam logic [1:0] WAIT_HIGH   = 2'd1;
  localparam logic [1:0] STABLE_HIGH = 2'd2;
  localparam logic [1:0] WAIT_LOW    = 2'd3;

  // Last count value before acceptance, and the increment step, sized to the counter.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1;
  logic             s2;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             d_nxt;
  logic             rise_nxt;
  logic             fall_nxt;

  // Two-stage synchronizer: nothing downstream ever looks at btn_in directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  // Next-state logic: count consecutive cycles of the opposite level, accept at CNT_LAST.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    d_nxt     = d_out;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      STABLE_LOW: begin
        d_nxt = 1'b0;
        if (s2) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = CNT_ZERO;
        end
      end
      WAIT_HIGH: begin
        d_nxt = 1'b0;
        if (!s2) begin
          // Glitch ended before acceptance: drop the partial count.
          state_nxt = STABLE_LOW;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_HIGH;
          cnt_nxt   = CNT_ZERO;
          d_nxt     = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        d_nxt = 1'b1;
        if (!s2) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = CNT_ZERO;
        end
      end
      WAIT_LOW: begin
        d_nxt = 1'b1;
        if (s2) begin
          state_nxt = STABLE_HIGH;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_LOW;
          cnt_nxt   = CNT_ZERO;
          d_nxt     = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      default: begin
        // Any corrupted encoding falls back to a quiet low state.
        state_nxt = STABLE_LOW;
        cnt_nxt   = CNT_ZERO;
        d_nxt     = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs; reset forces everything low at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= STABLE_LOW;
      cnt        <= CNT_ZERO;
      d_out      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      d_out      <= d_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
    end
  end

endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: directed and random-burst stimulus for debounce_sync.
// A behavioural model (sample history plus run length of the opposite level)
// pushes the expected {d_out, rise_pulse, fall_pulse} per clock into a queue;
// the value is popped and compared on the following falling edge.
module tb_debounce_sync;

  localparam int DC = 4;

  logic clk;
  logic rst_n;
  logic btn_in;
  logic d_out;
  logic rise_pulse;
  logic fall_pulse;

  int checks;
  int errors;
  int pulses_seen;

  logic [2:0] exp_q[$];

  // Reference model state
  logic m_s1;
  logic m_s2;
  logic m_d;
  int   m_run;

  debounce_sync #(.DEBOUNCE_CYCLES(DC), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (btn_in),
    .d_out      (d_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed {d,rise,fall}=%b expected %b", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_s1  = 1'b0;
    m_s2  = 1'b0;
    m_d   = 1'b0;
    m_run = 0;
    exp_q.delete();
  endtask

  // One rising edge of the model: the FSM sees the sample taken two edges ago.
  task automatic model_edge(input logic b);
    logic h;
    logic rise;
    logic fall;
    h    = m_s2;
    m_s2 = m_s1;
    m_s1 = b;
    rise = 1'b0;
    fall = 1'b0;
    if (h != m_d) begin
      m_run++;
      if (m_run == DC) begin
        m_d   = h;
        m_run = 0;
        rise  = h;
        fall  = ~h;
      end
    end else begin
      m_run = 0;
    end
    exp_q.push_back({m_d, rise, fall});
  endtask

  // Drive one input value across one rising edge and check against the model.
  task automatic cycle(input logic b, input string tag, output logic [2:0] obs);
    logic [2:0] expv;
    btn_in = b;
    @(posedge clk);
    model_edge(b);
    @(negedge clk);
    obs = {d_out, rise_pulse, fall_pulse};
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty, observed %b expected an entry", tag, obs);
    end else begin
      expv = exp_q.pop_front();
      check(tag, obs, expv);
    end
    if (rise_pulse === 1'b1) pulses_seen++;
    if (fall_pulse === 1'b1) pulses_seen++;
  endtask

  // Assert reset between edges, check outputs clear without a clock, hold over one edge.
  task automatic async_reset(input logic b, input string tag);
    btn_in = b;
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_async"}, {d_out, rise_pulse, fall_pulse}, 3'b000);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check({tag, "_held"}, {d_out, rise_pulse, fall_pulse}, 3'b000);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] obs;
    logic       cur;
    logic       nxt;
    int         changes;
    int         blen;

    checks      = 0;
    errors      = 0;
    pulses_seen = 0;
    clk         = 1'b0;
    btn_in      = 1'b0;
    rst_n       = 1'b0;
    model_reset();

    // Reset state before any clock edge.
    #3;
    check("reset_initial", {d_out, rise_pulse, fall_pulse}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    // Constant low: no pulses.
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, "const_low_model", obs);
      check("const_low", obs, 3'b000);
    end

    // Rise: accepted at E5 only.
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, "rise_model", obs);
      check("rise_latency", obs, {(k >= 5) ? 1'b1 : 1'b0, (k == 5) ? 1'b1 : 1'b0, 1'b0});
    end

    // Fall from stable high: fall_pulse at E5 only.
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, "fall_model", obs);
      check("fall_latency", obs, {(k >= 5) ? 1'b0 : 1'b1, 1'b0, (k == 5) ? 1'b1 : 1'b0});
    end

    // Longest rejectable bounce: three high cycles then low.
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, "bounce_model", obs);
      check("bounce_high", obs, 3'b000);
    end
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, "bounce_model", obs);
      check("bounce_low", obs, 3'b000);
    end
    // Then held high: full latency from the final 0->1.
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, "rise2_model", obs);
      check("rise_after_bounce", obs, {(k >= 5) ? 1'b1 : 1'b0, (k == 5) ? 1'b1 : 1'b0, 1'b0});
    end

    // Return low, then reset in the middle of a rise count.
    for (int k = 0; k < 8; k++) cycle(1'b0, "settle_low", obs);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, "midcount_model", obs);
      check("midcount", obs, 3'b000);
    end
    async_reset(1'b0, "reset_midcount");
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, "post_reset_low_model", obs);
      check("post_reset_low", obs, 3'b000);
    end

    // Reset while d_out is high, input kept high across reset.
    for (int k = 0; k < 8; k++) cycle(1'b1, "go_high", obs);
    check("high_before_reset", obs, 3'b100);
    async_reset(1'b1, "reset_high");
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, "post_reset_rise_model", obs);
      check("post_reset_rise", obs, {(k >= 5) ? 1'b1 : 1'b0, (k == 5) ? 1'b1 : 1'b0, 1'b0});
    end

    // Random bounce bursts between 10-cycle stable periods.
    cur         = 1'b1;
    changes     = 0;
    pulses_seen = 0;
    for (int p = 0; p < 16; p++) begin
      nxt  = 1'($urandom_range(0, 1));
      blen = int'($urandom_range(1, 3));
      if (nxt != cur) changes++;
      for (int b = 0; b < blen; b++) cycle(1'($urandom_range(0, 1)), "burst", obs);
      for (int s = 0; s < 10; s++) cycle(nxt, "burst_stable", obs);
      check("burst_level", {obs[2], 2'b00}, {nxt, 2'b00});
      cur = nxt;
    end
    checks++;
    assert (pulses_seen == changes) else begin
      errors++;
      $error("FAIL burst_pulse_count: observed %0d pulses expected %0d", pulses_seen, changes);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
- REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, number of consecutive synchronized cycles a new input level must hold before acceptance; legal range 2..65535.
- REQ-002 Parameter: CNT_W, default 16, stability-counter width; SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
- REQ-004 Port: rst_n  input  1  reset; asynchronous assertion, active-low.
- REQ-005 Port: btn_in  input  1  raw asynchronous, bouncy level from an external contact.
- REQ-006 Port: d_out  output  1  debounced, clock-synchronous level; this is the data input for the downstream D flip-flop stage.
- REQ-007 Port: rise_pulse  output  1  one-cycle strobe when d_out goes 0->1.
- REQ-008 Port: fall_pulse  output  1  one-cycle strobe when d_out goes 1->0.

Function
- REQ-009 btn_in SHALL pass through a two-stage flip-flop synchronizer (s1, s2) before any other logic uses it; no combinational path from btn_in to any output.
- REQ-010 FSM states: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
- REQ-011 STABLE_LOW: d_out=0, counter=0; s2=1 -> WAIT_HIGH with counter=1; else remain.
- REQ-012 WAIT_HIGH: s2=0 -> STABLE_LOW, counter=0, no pulse; s2=1 and counter=DEBOUNCE_CYCLES-1 -> STABLE_HIGH, d_out=1, rise_pulse=1, counter=0; otherwise counter+1.
- REQ-013 STABLE_HIGH and WAIT_LOW SHALL mirror REQ-011/REQ-012 with polarities inverted, fall_pulse instead of rise_pulse.
- REQ-014 Latency: if btn_in changes before rising edge E0 and holds, d_out and the matching pulse SHALL change at edge E(DEBOUNCE_CYCLES+1) and not earlier.
- REQ-015 Any reversion of s2 before acceptance (glitch shorter than DEBOUNCE_CYCLES synchronized cycles) SHALL discard the count; d_out and pulses unchanged.
- REQ-016 rise_pulse and fall_pulse SHALL be registered, high for exactly one clk cycle, never simultaneously high, and only in the cycle d_out changes.
- REQ-017 Counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL not wrap; it is zero whenever the FSM is in a STABLE state.
- REQ-018 A constant input SHALL produce no pulses indefinitely.
- REQ-019 Unreachable state encodings SHALL recover to STABLE_LOW on the next edge with d_out=0 and no pulse.

Reset
- REQ-020 rst_n=0 SHALL immediately, without a clock edge, force s1=0, s2=0, state=STABLE_LOW, counter=0, d_out=0, rise_pulse=0, fall_pulse=0.
- REQ-021 Reset asserted mid-count (WAIT_HIGH/WAIT_LOW) SHALL abandon the count; no pulse is emitted for it.
- REQ-022 After rst_n deasserts, if btn_in is already 1, a normal rise sequence (REQ-014 latency from the first post-reset edge) SHALL occur.

Verification (DEBOUNCE_CYCLES=4)
- REQ-023 Reset then btn_in=0 for 20 cycles -> d_out=0, no pulses throughout.
- REQ-024 btn_in 0->1 before edge E0, held -> d_out=1 and rise_pulse=1 at E5 only, rise_pulse=0 at E6.
- REQ-025 btn_in high for 3 cycles then low (bounce) -> d_out stays 0, no pulse; then held high -> rise after full 5-edge latency measured from the final 0->1.
- REQ-026 From stable high, btn_in 1->0 held -> fall_pulse one cycle at E5, d_out=0; rise_pulse stays 0.
- REQ-027 rst_n pulsed low while in WAIT_HIGH with counter=2 -> outputs 0 asynchronously, no rise_pulse after release while btn_in=0.
- REQ-028 Random bounce bursts of 1-3 cycles between 10-cycle stable periods -> exactly one pulse per stable-level change, matching a reference model.
